// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Holds the fetch state encoding and the opcode length rule.
package cpu_pkg;

  localparam int REG_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;
  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

  typedef enum logic [2:0] {
    VEC_LO,
    VEC_HI,
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    HOLD
  } fetch_state_e;

  // Opcode is aaa_bbb_cc; the group bits cc pick the addressing table.
  function automatic logic [1:0] ins_length(input logic [7:0] op);
    logic [2:0] b;
    logic [1:0] c;
    logic [1:0] len;
    b = op[4:2];
    c = op[1:0];
    len = 2'd2;
    if (c == 2'b11) begin
      len = 2'd1;
    end else if (c == 2'b01) begin
      if (b == 3'b011 || b == 3'b110 || b == 3'b111) len = 2'd3;
      else len = 2'd2;
    end else if (b == 3'b011 || b == 3'b111) begin
      len = 2'd3;
    end else if (b == 3'b010 || b == 3'b110) begin
      len = 2'd1;
    end else if (b == 3'b001 || b == 3'b100 || b == 3'b101) begin
      len = 2'd2;
    end else if (c == 2'b00) begin
      if (op == 8'h20) len = 2'd3;
      else if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
      else len = 2'd2;
    end else begin
      len = 2'd2;
    end
    return len;
  endfunction

endpackage

// File: rtl/ins_len_decode.sv
// Combinational opcode to instruction length.
// Shared by fetch and decode.
module ins_len_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [1:0] len_o
);

  assign len_o = ins_length(opcode_i);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: vector read, byte fetch, sizing,
// and valid/ready presentation of whole instructions to decode.
module fetch_unit #(
  parameter int DATA_WIDTH = cpu_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ack,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_val,
  output logic [DATA_WIDTH-1:0] fetch_out,
  output logic [DATA_WIDTH-1:0] op_lo,
  output logic [DATA_WIDTH-1:0] op_hi,
  output logic [1:0]            ins_len,
  output logic [ADDR_WIDTH-1:0] ins_pc,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  import cpu_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] vlo_q, vlo_d;
  logic [1:0]            len_q, len_d;
  logic                  rd_q, rd_d;
  logic [1:0]            dec_len;
  logic                  xfer;
  logic                  redirect;

  ins_len_decode u_len (
    .opcode_i (mem_data),
    .len_o    (dec_len)
  );

  assign xfer = rd_q && mem_ack;
  assign redirect = pc_load &&
                    state_q != VEC_LO &&
                    state_q != VEC_HI;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= VEC_LO;
      pc_q    <= RESET_VECTOR;
      ipc_q   <= '0;
      op_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      vlo_q   <= '0;
      len_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      vlo_q   <= vlo_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
    end
  end

  // A request goes out one cycle after entering a fetch state and
  // drops for one cycle after each ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    op_d    = op_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    vlo_d   = vlo_q;
    len_d   = len_q;
    rd_d    = rd_q;
    if (redirect) begin
      state_d = FETCH_OP;
      pc_d    = pc_load_val;
      lo_d    = '0;
      hi_d    = '0;
      rd_d    = 1'b0;
    end else begin
      unique case (state_q)
        VEC_LO: begin
          rd_d = 1'b1;
          if (xfer) begin
            vlo_d   = mem_data;
            pc_d    = pc_q + 1'b1;
            rd_d    = 1'b0;
            state_d = VEC_HI;
          end
        end
        VEC_HI: begin
          rd_d = 1'b1;
          if (xfer) begin
            pc_d    = {mem_data, vlo_q};
            rd_d    = 1'b0;
            state_d = FETCH_OP;
          end
        end
        FETCH_OP: begin
          rd_d = 1'b1;
          if (xfer) begin
            op_d    = mem_data;
            ipc_d   = pc_q;
            pc_d    = pc_q + 1'b1;
            len_d   = dec_len;
            rd_d    = 1'b0;
            state_d = (dec_len == 2'd1) ? HOLD : FETCH_LO;
          end
        end
        FETCH_LO: begin
          rd_d = 1'b1;
          if (xfer) begin
            lo_d    = mem_data;
            pc_d    = pc_q + 1'b1;
            rd_d    = 1'b0;
            state_d = (len_q == 2'd3) ? FETCH_HI : HOLD;
          end
        end
        FETCH_HI: begin
          rd_d = 1'b1;
          if (xfer) begin
            hi_d    = mem_data;
            pc_d    = pc_q + 1'b1;
            rd_d    = 1'b0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          rd_d = 1'b0;
          if (ins_ready) begin
            lo_d    = '0;
            hi_d    = '0;
            state_d = FETCH_OP;
          end
        end
        default: begin
          state_d = VEC_LO;
          rd_d    = 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = rd_q;
  assign mem_addr  = rd_q ? pc_q : '0;
  assign fetch_out = op_q;
  assign op_lo     = lo_q;
  assign op_hi     = hi_q;
  assign ins_len   = len_q;
  assign ins_pc    = ipc_q;
  assign ins_valid = (state_q == HOLD);
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, instruction
// scoreboard, length table and hand-written corner sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [7:0]  fetch_out;
  logic [7:0]  op_lo;
  logic [7:0]  op_hi;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [15:0] pc_out;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .fetch_out   (fetch_out),
    .op_lo       (op_lo),
    .op_hi       (op_hi),
    .ins_len     (ins_len),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  len;
    logic [15:0] pc;
  } ins_t;

  typedef struct {
    logic [7:0] opc;
    logic [1:0] len;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  mem [0:65535];
  int          lat;
  int          wcnt;
  logic        chk_stable;
  logic        prev_pend;
  logic [15:0] prev_addr;
  logic        log_en;
  logic [15:0] req_log [$];
  ins_t        exp_q [$];
  vec_t        tbl [20];
  logic [15:0] xaddr;

  assign mem_data = mem[mem_addr];
  assign mem_ack  = mem_rd && (wcnt >= lat);

  always @(posedge clk) begin
    if (mem_rd && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: one pop per accepted instruction.
  always @(negedge clk) begin
    if (!reset && ins_valid && ins_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ins: got pc %h op %h want none",
                 ins_pc, fetch_out);
      end else begin
        ins_t e;
        e = exp_q.pop_front();
        chk("ins", {22'd0, fetch_out, op_lo, op_hi, ins_len, ins_pc},
            {22'd0, e.op, e.lo, e.hi, e.len, e.pc});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_stable && mem_rd && prev_pend)
      chk("addr_stable", mem_addr, prev_addr);
    if (log_en && mem_rd && mem_ack)
      req_log.push_back(mem_addr);
    prev_pend <= mem_rd && !mem_ack;
    prev_addr <= mem_addr;
  end

  task automatic put(input logic [15:0] a, input logic [7:0] opc,
                     input logic [7:0] lo, input logic [7:0] hi,
                     input logic [1:0] len);
    ins_t e;
    mem[a] = opc;
    if (len >= 2) mem[a + 16'd1] = lo;
    if (len == 3) mem[a + 16'd2] = hi;
    e.op  = opc;
    e.lo  = (len >= 2) ? lo : 8'h00;
    e.hi  = (len == 3) ? hi : 8'h00;
    e.len = len;
    e.pc  = a;
    exp_q.push_back(e);
  endtask

  task automatic next_req(input logic [15:0] a, input string nm);
    int k;
    k = 0;
    while (!mem_rd && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(nm, mem_addr, a);
    k = 0;
    while (!(mem_rd && mem_ack) && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int k;
    reset = 1'b1;
    pc_load = 1'b0;
    pc_load_val = 16'h0000;
    ins_ready = 1'b1;
    lat = 0;
    chk_stable = 1'b0;
    log_en = 1'b0;

    tbl[0]  = '{8'h20, 2'd3}; tbl[1]  = '{8'h00, 2'd1};
    tbl[2]  = '{8'h40, 2'd1}; tbl[3]  = '{8'h60, 2'd1};
    tbl[4]  = '{8'hA2, 2'd2}; tbl[5]  = '{8'hA0, 2'd2};
    tbl[6]  = '{8'h4C, 2'd3}; tbl[7]  = '{8'h0A, 2'd1};
    tbl[8]  = '{8'h18, 2'd1}; tbl[9]  = '{8'hFF, 2'd1};
    tbl[10] = '{8'h91, 2'd2}; tbl[11] = '{8'h99, 2'd3};
    tbl[12] = '{8'h1D, 2'd3}; tbl[13] = '{8'hBE, 2'd3};
    tbl[14] = '{8'h85, 2'd2}; tbl[15] = '{8'hD0, 2'd2};
    tbl[16] = '{8'h96, 2'd2}; tbl[17] = '{8'h6C, 2'd3};
    tbl[18] = '{8'h8A, 2'd1}; tbl[19] = '{8'hC8, 2'd1};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    put(16'h8000, 8'hAD, 8'h34, 8'h12, 2'd3);
    put(16'h8003, 8'hEA, 8'h00, 8'h00, 2'd1);
    put(16'h8004, 8'hA9, 8'h42, 8'h00, 2'd2);
    a = 16'h8006;
    for (int i = 0; i < 20; i++) begin
      put(a, tbl[i].opc, 8'h10 + 8'(i), 8'h80 + 8'(i), tbl[i].len);
      a = a + 16'(tbl[i].len);
    end
    xaddr = a;
    mem[a] = 8'hAD;
    mem[a + 16'd1] = 8'h55;
    mem[a + 16'd2] = 8'h66;
    put(16'hC000, 8'hEA, 8'h00, 8'h00, 2'd1);
    put(16'hFFFE, 8'h4C, 8'h00, 8'hC0, 2'd3);
    put(16'h0001, 8'hEA, 8'h00, 8'h00, 2'd1);

    @(negedge clk);
    chk("rst_rd", mem_rd, 0);
    chk("rst_valid", ins_valid, 0);
    chk("rst_pc", pc_out, 16'hFFFC);
    chk("rst_addr", mem_addr, 0);
    chk("rst_op", fetch_out, 0);
    chk("rst_lo", op_lo, 0);
    chk("rst_hi", op_hi, 0);
    chk("rst_len", ins_len, 0);
    chk("rst_ipc", ins_pc, 0);
    @(posedge clk); #1 reset = 1'b0;

    next_req(16'hFFFC, "vec_lo_req");
    next_req(16'hFFFD, "vec_hi_req");
    next_req(16'h8000, "first_op_req");

    k = 0;
    while (!(ins_valid && ins_pc == 16'h8000) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("lda_abs_valid", ins_valid, 1);
    @(posedge clk); #1 ins_ready = 1'b0;
    next_req(16'h8003, "after_lda_req");
    k = 0;
    while (!ins_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("nop_hold_valid", ins_valid, 1);
      chk("nop_hold_rd", mem_rd, 0);
      chk("nop_hold_op", fetch_out, 8'hEA);
      chk("nop_hold_len", ins_len, 1);
      chk("nop_hold_pc", ins_pc, 16'h8003);
      @(negedge clk);
    end
    lat = 3;
    chk_stable = 1'b1;
    @(posedge clk); #1 ins_ready = 1'b1;

    k = 0;
    while (!(ins_valid && ins_pc == 16'h8004) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("lda_imm_valid", ins_valid, 1);
    lat = 0;
    chk_stable = 1'b0;

    k = 0;
    while (!(mem_rd && mem_ack && mem_addr == xaddr + 16'd1) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("abort_point", mem_addr, xaddr + 16'd1);
    pc_load = 1'b1;
    pc_load_val = 16'hC000;
    @(posedge clk); #1 pc_load = 1'b0;
    chk("abort_valid", ins_valid, 0);
    chk("abort_lo", op_lo, 0);
    chk("abort_rd", mem_rd, 0);
    chk("abort_pc", pc_out, 16'hC000);
    next_req(16'hC000, "redirect_req");

    k = 0;
    while (!(ins_valid && ins_pc == 16'hC000) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("c000_valid", ins_valid, 1);
    pc_load = 1'b1;
    pc_load_val = 16'hFFFE;
    log_en = 1'b1;
    @(posedge clk); #1 pc_load = 1'b0;

    k = 0;
    while (!(ins_valid && ins_pc == 16'hFFFE) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("wrap_valid", ins_valid, 1);
    chk("wrap_len", ins_len, 3);
    chk("wrap_pc_out", pc_out, 16'h0001);
    log_en = 1'b0;
    chk("wrap_nreq", req_log.size(), 3);
    if (req_log.size() == 3) begin
      chk("wrap_req0", req_log[0], 16'hFFFE);
      chk("wrap_req1", req_log[1], 16'hFFFF);
      chk("wrap_req2", req_log[2], 16'h0000);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drained", exp_q.size(), 0);
    @(posedge clk); #1 ins_ready = 1'b0;

    k = 0;
    while (!ins_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("pre_reset_valid", ins_valid, 1);
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", ins_valid, 0);
    chk("mid_rst_pc", pc_out, 16'hFFFC);
    chk("mid_rst_rd", mem_rd, 0);
    chk("mid_rst_op", fetch_out, 0);
    chk("mid_rst_len", ins_len, 0);
    @(posedge clk); #1 reset = 1'b0;
    next_req(16'hFFFC, "rst2_vec_lo");
    next_req(16'hFFFD, "rst2_vec_hi");
    next_req(16'h8000, "rst2_first_op");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 6502-style CPU core. On reset it reads the reset vector, then reads opcode and operand bytes from memory at the program counter. It sizes each instruction from its opcode and presents a complete instruction (opcode, operand bytes, length, address) to decode through a valid/ready handshake. It is the stage directly upstream of decode, and decode drives the data-bus selectors. Its opcode byte is the bus's `fetch_in` source.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width (`REG_WIDTH`)
- `ADDR_WIDTH`, 16, address/PC width
- `RESET_VECTOR`, 16'hFFFC, address of reset vector low byte (high byte at +1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mem_addr`  out  ADDR_WIDTH  read address
- `mem_rd`  out  1  read request
- `mem_data`  in  DATA_WIDTH  read data, valid when `mem_rd && mem_ack`
- `mem_ack`  in  1  read completes this cycle
- `pc_load`  in  1  redirect request (jump/branch/interrupt)
- `pc_load_val`  in  ADDR_WIDTH  redirect target
- `fetch_out`  out  DATA_WIDTH  opcode
- `op_lo`  out  DATA_WIDTH  first operand byte (0 if absent)
- `op_hi`  out  DATA_WIDTH  second operand byte (0 if absent)
- `ins_len`  out  2  instruction length, 1–3
- `ins_pc`  out  ADDR_WIDTH  address of opcode
- `ins_valid`  out  1  instruction available
- `ins_ready`  in  1  decode accepts
- `pc_out`  out  ADDR_WIDTH  next fetch address

## Operation
- States: VEC_LO, VEC_HI, FETCH_OP, FETCH_LO, FETCH_HI, HOLD.
- Reset: state VEC_LO, PC = RESET_VECTOR, `mem_rd`=0. All data/address outputs are 0, `ins_valid`=0, `pc_out`=RESET_VECTOR.
- VEC_LO: read RESET_VECTOR and latch the low byte. VEC_HI: read RESET_VECTOR+1. PC = {hi,lo}, then go to FETCH_OP.
- FETCH_OP: read PC. On ack, latch the opcode, set `ins_pc`=PC and PC+=1, and compute the length.
  - Length 1: go to HOLD.
  - Otherwise: go to FETCH_LO.
- FETCH_LO: read PC. On ack, latch `op_lo` and PC+=1. Go to FETCH_HI if length 3, else HOLD.
- FETCH_HI: read PC. On ack, latch `op_hi`, PC+=1, go to HOLD.
- HOLD: `ins_valid`=1 and all instruction outputs are stable. On `ins_ready`, clear `op_lo`/`op_hi`, deassert `ins_valid`, go to FETCH_OP. There is no prefetch while holding.
- Length rule (opcode = aaa_bbb_cc):
  - cc=11: 1.
  - cc=01: 3 if bbb∈{011,110,111}, else 2.
  - cc=00/10, bbb∈{011,111}: 3.
  - bbb∈{010,110}: 1.
  - bbb∈{001,100,101}: 2.
  - bbb=000, cc=00: 20h→3, 00h/40h/60h→1, else 2.
  - bbb=000, cc=10: 2.
- PC arithmetic is modulo 2^ADDR_WIDTH (FFFF+1 = 0000). Operand fetch across the wrap is legal.
- `pc_load` in FETCH_*/HOLD: at the next edge PC = `pc_load_val`, `ins_valid`=0, operand regs cleared, state FETCH_OP. Any in-flight read is abandoned. Any `mem_ack` in the load cycle is ignored.
- `pc_load` with `ins_valid && ins_ready` in the same cycle: the transfer counts as accepted and the redirect is applied.
- `pc_load` during VEC_LO/VEC_HI is ignored.

## Timing
- `mem_rd` is registered and asserted the cycle after entering a fetch state. `mem_addr` = PC, held stable until the ack.
- Memory may ack in the same cycle as `mem_rd` or any later cycle. The transfer occurs only when `mem_rd && mem_ack`.
- After an ack, `mem_rd` drops for one cycle before the next request. Minimum 2 cycles per byte.
- `ins_valid` rises the cycle after the final byte ack.
- With zero-wait memory, a 3-byte instruction is presented 6 cycles after entering FETCH_OP.
- Handshake: `ins_valid` never drops without `ins_ready` or `pc_load`. Outputs are constant while valid.
- Reset mid-operation: immediate return to reset values and restart at the vector.

## Structure
- Shared `cpu_pkg`:
  - state enum
  - `ins_length(opcode)` function
  - `RESET_VECTOR` default
  - `REG_WIDTH`/`ADDR_WIDTH` constants
- One sub-module, `ins_len_decode`: combinational opcode→length, reused later by decode.
- Remainder is a single FSM with PC register and output latches.

## Test plan
- Reset, memory [FFFC]=00h, [FFFD]=80h, zero-wait, `ins_ready`=1 → first request `mem_addr`=8000h.
- [8000]=AD,34,12 (LDA abs) → `fetch_out`=ADh, `op_lo`=34h, `op_hi`=12h, `ins_len`=3, `ins_pc`=8000h. Next fetch at 8003h.
- [8003]=EA (NOP) with `ins_ready`=0 for 5 cycles → `ins_valid` held 5+ cycles, outputs stable, no `mem_rd` asserted, `ins_len`=1.
- `mem_ack` delayed 3 cycles on A9,42 (LDA #) → `mem_addr` stable throughout, result `op_lo`=42h, `ins_len`=2.
- `pc_load`=1, `pc_load_val`=C000h during FETCH_LO, with ack in the same cycle → byte discarded, next request at C000h, no valid for the aborted instruction.
- PC at FFFEh, [FFFE]=4C,00 (JMP abs) → operand reads at FFFFh then 0000h, `ins_len`=3, PC wraps to 0001h.
